// File: rtl/nubus_video_pkg.sv
// Shared types and widths for the NuBus video VRAM requester.
package nubus_video_pkg;

  localparam int VRAM_AW = 25;
  localparam int VRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    GAP  = 2'd3
  } fetch_state_e;

  // Framebuffer word address, wrapping modulo 2^25.
  function automatic logic [VRAM_AW-1:0] vram_word_addr(
    input logic [VRAM_AW-1:0] base,
    input logic [17:0]        offset
  );
    return base + {7'd0, offset};
  endfunction

endpackage

// File: rtl/vram_scan_fifo.sv
// First-word fall-through scanout FIFO with synchronous flush and level output.
module vram_scan_fifo
  import nubus_video_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               push,
  input  logic [VRAM_DW-1:0] push_data,
  input  logic               pop,
  output logic [VRAM_DW-1:0] head,
  output logic               not_empty,
  output logic [AW:0]        count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [VRAM_DW-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;
  logic               do_pop_s;
  logic               do_push_s;

  assign do_pop_s  = pop && (count_r != {(AW + 1){1'b0}});
  assign do_push_s = push && ((count_r != FULL_COUNT) || do_pop_s);

  // Pointer and level bookkeeping; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Word storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {VRAM_DW{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head      = mem_r[rd_ptr_r];
  assign not_empty = (count_r != {(AW + 1){1'b0}});
  assign count     = count_r;

endmodule

// File: rtl/nubus_vram_fetcher.sv
// VRAM requester: scanout prefetch into a FIFO plus posted pixel writes, one transfer in flight.
// Optional underflow statistics counter is built when VRAM_FETCH_STATS_EN is defined.
module nubus_vram_fetcher
  import nubus_video_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int LOW_WATER  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [VRAM_AW-1:0] fb_base,
  input  logic [17:0]        frame_words,
  input  logic               frame_start,
  output logic [VRAM_DW-1:0] pix_data,
  output logic               pix_valid,
  input  logic               pix_rd,
  output logic               underflow,
  input  logic               wr_req,
  input  logic [VRAM_AW-1:0] wr_addr,
  input  logic [VRAM_DW-1:0] wr_data,
  output logic               wr_ack,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [VRAM_DW-1:0] vram_dout,
  input  logic [VRAM_DW-1:0] vram_din,
  output logic               vram_rd,
  output logic               vram_wr,
  input  logic               vram_ready,
  output logic [15:0]        underflow_count
);

  localparam logic [FIFO_AW:0] LOW_LEVEL  = (FIFO_AW + 1)'(LOW_WATER);
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(FIFO_DEPTH);

  fetch_state_e       state_r, state_n;
  logic [17:0]        offset_r, offset_n;
  logic [VRAM_AW-1:0] addr_r, addr_n;
  logic [VRAM_DW-1:0] dout_r, dout_n;
  logic               rd_r, rd_n;
  logic               wr_r, wr_n;
  logic               discard_r, discard_n;
  logic               underflow_r, underflow_n;
  logic               wr_ack_s;

  logic [FIFO_AW:0]   fifo_count_s;
  logic               fifo_not_empty_s;
  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic [17:0]        frame_len_s;
  logic [17:0]        offset_inc_s;
  logic [17:0]        read_offset_s;
  logic               empty_pop_s;

  assign frame_len_s   = (frame_words == 18'd0) ? 18'd1 : frame_words;
  assign offset_inc_s  = offset_r + 18'd1;
  assign read_offset_s = frame_start ? 18'd0 : offset_r;
  assign empty_pop_s   = pix_rd && !fifo_not_empty_s;
  assign fifo_pop_s    = pix_rd && !frame_start;
  assign fifo_push_s   = (state_r == RD) && vram_ready && !discard_r && !frame_start;

  vram_scan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (frame_start),
    .push      (fifo_push_s),
    .push_data (vram_din),
    .pop       (fifo_pop_s),
    .head      (pix_data),
    .not_empty (fifo_not_empty_s),
    .count     (fifo_count_s)
  );

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_n     = state_r;
    offset_n    = offset_r;
    addr_n      = addr_r;
    dout_n      = dout_r;
    rd_n        = rd_r;
    wr_n        = wr_r;
    discard_n   = discard_r;
    underflow_n = underflow_r;
    wr_ack_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (fifo_count_s < LOW_LEVEL) begin
          state_n = RD;
          addr_n  = vram_word_addr(fb_base, read_offset_s);
          rd_n    = 1'b1;
        end else if (wr_req) begin
          state_n = WR;
          addr_n  = wr_addr;
          dout_n  = wr_data;
          wr_n    = 1'b1;
        end else if (fifo_count_s < FULL_LEVEL) begin
          state_n = RD;
          addr_n  = vram_word_addr(fb_base, read_offset_s);
          rd_n    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RD: begin
        if (vram_ready) begin
          state_n   = GAP;
          rd_n      = 1'b0;
          discard_n = 1'b0;
          // A read overtaken by frame_start leaves the new frame starting at offset 0.
          if (discard_r || frame_start) begin
            offset_n = 18'd0;
          end else if (offset_inc_s == frame_len_s) begin
            offset_n = 18'd0;
          end else begin
            offset_n = offset_inc_s;
          end
        end else if (frame_start) begin
          discard_n = 1'b1;
        end else begin
          discard_n = discard_r;
        end
      end
      WR: begin
        if (vram_ready) begin
          state_n  = GAP;
          wr_n     = 1'b0;
          wr_ack_s = 1'b1;
        end else begin
          state_n = WR;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n   = IDLE;
        rd_n      = 1'b0;
        wr_n      = 1'b0;
        discard_n = 1'b0;
      end
    endcase

    if (frame_start) begin
      offset_n    = 18'd0;
      underflow_n = 1'b0;
    end else if (empty_pop_s) begin
      underflow_n = 1'b1;
    end else begin
      underflow_n = underflow_r;
    end
  end

  // Sequencer state and registered VRAM request outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      offset_r    <= 18'd0;
      addr_r      <= {VRAM_AW{1'b0}};
      dout_r      <= {VRAM_DW{1'b0}};
      rd_r        <= 1'b0;
      wr_r        <= 1'b0;
      discard_r   <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      offset_r    <= offset_n;
      addr_r      <= addr_n;
      dout_r      <= dout_n;
      rd_r        <= rd_n;
      wr_r        <= wr_n;
      discard_r   <= discard_n;
      underflow_r <= underflow_n;
    end
  end

  assign vram_addr = addr_r;
  assign vram_dout = dout_r;
  assign vram_rd   = rd_r;
  assign vram_wr   = wr_r;
  assign wr_ack    = wr_ack_s;
  assign pix_valid = fifo_not_empty_s;
  assign underflow = underflow_r;

`ifdef VRAM_FETCH_STATS_EN
  logic [15:0] uf_count_r;

  // Saturating count of pops attempted on an empty FIFO; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uf_count_r <= 16'd0;
    end else if (empty_pop_s && (uf_count_r != 16'hFFFF)) begin
      uf_count_r <= uf_count_r + 16'd1;
    end
  end

  assign underflow_count = uf_count_r;
`else
  assign underflow_count = 16'd0;
`endif

endmodule

// File: tb/tb_nubus_vram_fetcher.sv
// Scoreboard bench: stimulus queues expected VRAM requests and pixel words, monitors compare.
`timescale 1ns/1ps
module tb_nubus_vram_fetcher;

  localparam logic [24:0] FB = 25'h100000;
  localparam int          FW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] fb_base = 25'd0;
  logic [17:0] frame_words = 18'd0;
  logic        frame_start = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_rd = 1'b0;
  logic        underflow;
  logic        wr_req = 1'b0;
  logic [24:0] wr_addr = 25'd0;
  logic [15:0] wr_data = 16'd0;
  logic        wr_ack;
  logic [24:0] vram_addr;
  logic [15:0] vram_dout;
  logic [15:0] vram_din = 16'd0;
  logic        vram_rd;
  logic        vram_wr;
  logic        vram_ready = 1'b0;
  logic [15:0] underflow_count;

  typedef struct packed {
    logic        is_wr;
    logic [24:0] addr;
    logic [15:0] data;
  } req_t;

  req_t        exp_q[$];
  logic [15:0] pix_q[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 4;
  int          ack_exp = 0;
  logic [17:0] exp_off = 18'd0;

`ifdef VRAM_FETCH_STATS_EN
  localparam logic [15:0] UF_EXP = 16'd3;
`else
  localparam logic [15:0] UF_EXP = 16'd0;
`endif

  nubus_vram_fetcher dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fb_base         (fb_base),
    .frame_words     (frame_words),
    .frame_start     (frame_start),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .pix_rd          (pix_rd),
    .underflow       (underflow),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ack          (wr_ack),
    .vram_addr       (vram_addr),
    .vram_dout       (vram_dout),
    .vram_din        (vram_din),
    .vram_rd         (vram_rd),
    .vram_wr         (vram_wr),
    .vram_ready      (vram_ready),
    .underflow_count (underflow_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [24:0] a);
    return a[15:0] ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reads(input int n, input bit keep);
    logic [24:0] a;
    for (int i = 0; i < n; i++) begin
      a = FB + {7'd0, exp_off};
      exp_q.push_back('{is_wr: 1'b0, addr: a, data: 16'h0000});
      if (keep) pix_q.push_back(mem_word(a));
      exp_off = (exp_off + 18'd1 == 18'(FW)) ? 18'd0 : exp_off + 18'd1;
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Arbiter model: ready for one cycle after lat cycles of held request; checks the request held stable.
  initial begin
    int   cnt = 0;
    req_t cap = '0;
    forever begin
      @(posedge clk);
      #1;
      if (vram_ready) begin
        vram_ready = 1'b0;
        cnt = 0;
      end else if (vram_rd || vram_wr) begin
        cnt++;
        if (cnt == 1) cap = '{is_wr: vram_wr, addr: vram_addr, data: vram_dout};
        if (cnt >= lat) begin
          chk("req_hold", {6'd0, vram_wr, vram_addr}, {6'd0, cap.is_wr, cap.addr});
          chk("dout_hold", vram_dout, cap.data);
          vram_din   = vram_wr ? 16'h0000 : mem_word(vram_addr);
          vram_ready = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: request starts, write acks and pixel pops against the queued expectations.
  initial begin
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    int   low_cnt = 100;
    req_t e;
    forever begin
      @(negedge clk);
      if ((vram_rd || vram_wr) && !prev_req) begin
        chk("gap_before_req", (low_cnt >= 2), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got rd=%0b wr=%0b addr=0x%0h, expected no request", vram_rd, vram_wr, vram_addr);
        end else begin
          e = exp_q.pop_front();
          chk("req_kind", {vram_wr, vram_rd}, {e.is_wr, !e.is_wr});
          chk("req_addr", vram_addr, e.addr);
          if (e.is_wr) chk("req_data", vram_dout, e.data);
        end
      end
      if (vram_rd || vram_wr) low_cnt = 0;
      else low_cnt++;
      prev_req = vram_rd || vram_wr;

      if (wr_ack) begin
        chk("ack_single_cycle", prev_ack, 0);
        if (ack_exp > 0) begin
          ack_exp--;
          chk("ack_with_ready", (vram_wr && vram_ready), 1);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got wr_ack=1, expected 0");
        end
      end
      prev_ack = wr_ack;

      if (pix_rd && pix_valid) begin
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected: got 0x%0h, expected empty FIFO", pix_data);
        end else begin
          chk("pix_data", pix_data, pix_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fb_base     = FB;
    frame_words = 18'(FW);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vram_rd", vram_rd, 0);
    chk("rst_vram_wr", vram_wr, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_vram_dout", vram_dout, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_uf_count", underflow_count, 0);

    // Fill from reset: two passes over the 8-word frame, then stop at full.
    expect_reads(16, 1'b1);
    step();
    reset_n     = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_drain(400, "t1_reads_issued");
    repeat (30) step();
    chk("t1_full_valid", pix_valid, 1);

    // One pop refills exactly one word.
    expect_reads(1, 1'b1);
    pix_rd = 1'b1;
    step();
    pix_rd = 1'b0;
    wait_drain(60, "t2_refill_issued");
    repeat (20) step();

    // Write posted at level >= LOW_WATER goes ahead of the refill reads.
    exp_q.push_back('{is_wr: 1'b1, addr: 25'h1FFFF0, data: 16'hA5A5});
    ack_exp = 1;
    expect_reads(4, 1'b1);
    wr_req  = 1'b1;
    wr_addr = 25'h1FFFF0;
    wr_data = 16'hA5A5;
    pix_rd  = 1'b1;
    repeat (4) step();
    pix_rd = 1'b0;
    begin
      int n = 0;
      while (ack_exp != 0 && n < 60) begin
        step();
        n++;
      end
    end
    chk("t3_ack_seen", ack_exp, 0);
    wr_req = 1'b0;
    wait_drain(100, "t3_reads_issued");
    repeat (20) step();

    // Long stall on one read.
    lat = 40;
    expect_reads(1, 1'b1);
    pix_rd = 1'b1;
    step();
    pix_rd = 1'b0;
    wait_drain(60, "t4_read_issued");
    repeat (60) step();
    lat = 4;
    repeat (10) step();

    // frame_start while a read is in flight: word discarded, restart at fb_base.
    expect_reads(1, 1'b0);
    pix_rd = 1'b1;
    step();
    pix_rd = 1'b0;
    wait_drain(60, "t5_read_issued");
    step();
    frame_start = 1'b1;
    pix_q.delete();
    exp_off = 18'd0;
    expect_reads(16, 1'b1);
    step();
    frame_start = 1'b0;
    @(negedge clk);
    chk("t5_flushed_empty", pix_valid, 0);
    wait_drain(400, "t5_refill_issued");
    repeat (30) step();

    // Underflow: flush under a slow arbiter, then pop an empty FIFO three times.
    lat = 60;
    frame_start = 1'b1;
    pix_q.delete();
    exp_off = 18'd0;
    expect_reads(16, 1'b1);
    step();
    frame_start = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("t6_empty", pix_valid, 0);
    step();
    pix_rd = 1'b1;
    repeat (3) step();
    pix_rd = 1'b0;
    @(negedge clk);
    chk("t6_underflow_set", underflow, 1);
    chk("t6_uf_count", underflow_count, UF_EXP);
    lat = 4;
    wait_drain(400, "t6_refill_issued");
    repeat (30) step();
    chk("t6_underflow_sticky", underflow, 1);
    frame_start = 1'b1;
    pix_q.delete();
    exp_off = 18'd0;
    expect_reads(16, 1'b1);
    step();
    frame_start = 1'b0;
    @(negedge clk);
    chk("t6_underflow_cleared", underflow, 0);
    chk("t6_uf_count_kept", underflow_count, UF_EXP);
    wait_drain(400, "t6_second_refill");
    repeat (30) step();

    // Drain a few words to confirm FIFO contents after the flush.
    expect_reads(3, 1'b1);
    pix_rd = 1'b1;
    repeat (3) step();
    pix_rd = 1'b0;
    wait_drain(100, "final_reads_issued");
    repeat (20) step();
    chk("final_ack_outstanding", ack_exp, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nubus_vram_fetcher.md
Name: nubus_vram_fetcher

Overview:
- Requester side of the NuBus video card's VRAM port into the SDRAM arbiter.
- Continuously prefetches framebuffer words for scanout into a local FIFO.
- Posts single-word pixel writes from the NuBus slave logic.
- Drives vram_rd/vram_wr/vram_addr and completes each transfer on vram_ready. The arbiter may starve this port indefinitely while the Mac core is active.

Parameters:
- FIFO_DEPTH, 16, scanout FIFO depth in 16-bit words (power of 2, ≥4).
- FIFO_AW, 4, log2(FIFO_DEPTH).
- LOW_WATER, 8, FIFO level below which reads take priority over a pending write.

Ports:
- clk  in  1  system clock (clk_sys domain; arbiter clock).
- reset_n  in  1  asynchronous active-low reset.
- fb_base  in  25  framebuffer base word address.
- frame_words  in  18  words per frame; 0 treated as 1.
- frame_start  in  1  one-cycle pulse at vertical blank: restart scanout.
- pix_data  out  16  FIFO head word.
- pix_valid  out  1  FIFO not empty.
- pix_rd  in  1  pop FIFO head (ignored when pix_valid=0).
- underflow  out  1  sticky; set by pix_rd while empty; cleared by frame_start.
- wr_req  in  1  post a write; held until wr_ack.
- wr_addr  in  25  write word address.
- wr_data  in  16  write data.
- wr_ack  out  1  one-cycle pulse when the write has completed in SDRAM.
- vram_addr  out  25  SDRAM word address.
- vram_dout  out  16  write data to arbiter.
- vram_din  in  16  read data from arbiter.
- vram_rd  out  1  read request.
- vram_wr  out  1  write request.
- vram_ready  in  1  transfer complete; valid only while the request is held.
- underflow_count  out  16  see Optional Feature.

Behaviour:
- Reset values: all outputs 0; FIFO empty; offset=0; FSM in IDLE.
- FSM states: IDLE, RD, WR, GAP.
- IDLE decision order:
  - (a) RD if count<LOW_WATER;
  - (b) else WR if wr_req;
  - (c) else RD if count<FIFO_DEPTH;
  - (d) else stay in IDLE.
- Entering RD/WR: register vram_addr/vram_dout, assert vram_rd or vram_wr on the next cycle.
- Address, data and request are held stable until vram_ready. There is no timeout.
- Exactly one operation is in flight, so the count<FIFO_DEPTH check guarantees room for the returned word.
- RD with vram_ready=1:
  - push vram_din;
  - offset <= (offset+1==frame_words) ? 0 : offset+1;
  - go to GAP.
- WR with vram_ready=1: pulse wr_ack the same cycle, go to GAP.
- GAP: both requests low for exactly one cycle, so the arbiter's grant history clears and a stale ready is never counted twice. GAP always returns to IDLE.
- Address arithmetic: vram_addr = fb_base + offset, 25-bit modulo 2^25. offset is zero-extended from 18 bits.
- FIFO: first-word fall-through. Push and pop in the same cycle leave count unchanged. Pop when empty is ignored and sets underflow.
- frame_start:
  - flush FIFO; offset <= 0; clear underflow.
  - If in RD, the read completes but its data is discarded (discard flag) and offset stays 0.
  - If in WR, the write completes normally.
  - Takes priority over a same-cycle push or pop.
- Simultaneous frame_start and vram_ready in RD: data discarded, offset stays 0.
- wr_req deasserted before wr_ack: undefined usage. The block finishes any WR already started.

Optional Feature:
- Macro: VRAM_FETCH_STATS_EN.
- Enabled: underflow_count is a 16-bit saturating counter of ignored pops on an empty FIFO. Cleared only by reset, not by frame_start.
- Disabled: underflow_count tied to 0; no counter logic.

Decomposition:
- Package nubus_video_pkg holds: FSM state enum (IDLE/RD/WR/GAP), VRAM_AW=25, VRAM_DW=16.
- One sub-module: vram_scan_fifo, a synchronous FWFT FIFO with flush, count output, and async active-low reset.

Test Plan:
1. Bench arbiter model gives ready 4 cycles after request; fb_base=0x100000, frame_words=8, frame_start, no pops → reads at 0x100000..0x100007, then 0x100000 again. FIFO reaches 16 and vram_rd stays low.
2. FIFO full, single pix_rd → exactly one read issued at the next sequential address, with a 1-cycle GAP before and after.
3. FIFO count=12, wr_req with addr 0x1FFFF0 and data 0xA5A5 → vram_wr with those values held until ready; wr_ack pulses 1 cycle; write issued before the next read.
4. Arbiter withholds ready for 40 cycles → vram_rd, vram_addr held constant, no FIFO push; completes normally afterwards.
5. frame_start while in RD → returned word discarded, pix_valid=0, next read at fb_base.
6. Empty FIFO, 3× pix_rd → underflow=1; underflow_count=3 with VRAM_FETCH_STATS_EN, 0 without; frame_start clears underflow only.
